// File: rtl/green_exec.sv
// Multi-cycle execute unit: IDLE -> EXEC -> (MEM) -> WB, with a small ALU,
// a branch-flag evaluator and a local word RAM for LD/ST.
module green_exec #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [15:0]       opCode,
   input  logic [DATA_W-1:0] A_in,
   input  logic [DATA_W-1:0] B_in,
   output logic [DATA_W-1:0] A_out,
   output logic [DATA_W-1:0] B_out,
   output logic [2:0]        ZNC_out,
   output logic              BR_out,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

   localparam logic [3:0] CLS_INCA = 4'd1;
   localparam logic [3:0] CLS_INCB = 4'd2;
   localparam logic [3:0] CLS_LD   = 4'd3;
   localparam logic [3:0] CLS_ST   = 4'd4;
   localparam logic [3:0] CLS_BR   = 4'd5;
   localparam logic [3:0] CLS_ADD  = 4'd6;

   state_t              state_q, state_d;
   logic [15:0]         op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
   logic [2:0]          znc_q, znc_d;
   logic                br_q, br_d;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic [3:0]          cls;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   add_x, add_y;
   logic [DATA_W:0]     sum;
   logic [2:0]          sum_znc;
   logic                mem_we;
   logic                op_unused;

   assign cls       = op_q[15:12];
   assign addr      = op_q[ADDR_W-1:0];
   assign op_unused = ^op_q;

   // One adder serves INCA, INCB and ADD; flags come from whichever word it produced.
   assign add_x   = (cls == CLS_INCB) ? b_q : a_q;
   assign add_y   = (cls == CLS_ADD) ? b_q : {{(DATA_W-1){1'b0}}, 1'b1};
   assign sum     = {1'b0, add_x} + {1'b0, add_y};
   assign sum_znc = {sum[DATA_W-1:0] == '0, sum[DATA_W-1], sum[DATA_W]};

   assign mem_we = en && (state_q == EXEC) && (cls == CLS_ST);

   // RAM has no reset; the read register is loaded on the EXEC->MEM edge.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr] <= b_q;
      if (en && state_q == EXEC) rdata_q <= mem[addr];
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      a_out_d = a_out_q;
      b_out_d = b_out_q;
      znc_d   = znc_q;
      br_d    = br_q;
      case (state_q)
         IDLE: if (en && op_valid) begin
            state_d = EXEC;
            op_d    = opCode;
            a_d     = A_in;
            b_d     = B_in;
         end
         EXEC: if (en) begin
            state_d = (cls == CLS_LD) ? MEM : WB;
            if (cls != CLS_LD) br_d = 1'b0;
            case (cls)
               CLS_INCA, CLS_ADD: begin
                  a_out_d = sum[DATA_W-1:0];
                  b_out_d = b_q;
                  znc_d   = sum_znc;
               end
               CLS_INCB: begin
                  a_out_d = a_q;
                  b_out_d = sum[DATA_W-1:0];
                  znc_d   = sum_znc;
               end
               CLS_ST: begin
                  a_out_d = a_q;
                  b_out_d = b_q;
               end
               CLS_BR: begin
                  a_out_d = a_q;
                  b_out_d = b_q;
                  br_d    = |(op_q[2:0] & znc_q);
               end
               default: ;
            endcase
         end
         MEM: if (en) begin
            state_d = WB;
            a_out_d = rdata_q;
            b_out_d = b_q;
            br_d    = 1'b0;
         end
         WB: if (en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         a_out_q <= '0;
         b_out_q <= '0;
         znc_q   <= 3'b000;
         br_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         a_out_q <= a_out_d;
         b_out_q <= b_out_d;
         znc_q   <= znc_d;
         br_q    <= br_d;
      end
   end

   assign op_ready = en && (state_q == IDLE);
   assign done     = en && (state_q == WB);
   assign A_out    = a_out_q;
   assign B_out    = b_out_q;
   assign ZNC_out  = znc_q;
   assign BR_out   = br_q;

endmodule

// File: tb/tb_green_exec.sv
// Randomized bench for green_exec against an op-level reference model,
// plus directed cases for wrap, LD/ST, branch, stall, back-to-back issue and reset.
module tb_green_exec;

   logic        clk = 1'b0;
   logic        rst_n, en, op_valid, op_ready, BR_out, done;
   logic [15:0] opCode, A_in, B_in, A_out, B_out;
   logic [2:0]  ZNC_out;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_a, m_b;
   logic [2:0]  m_znc;
   logic        m_br;
   logic [15:0] m_ram [256];

   always #5 clk = ~clk;

   green_exec #(.DATA_W(16), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .op_valid(op_valid), .op_ready(op_ready),
      .opCode(opCode), .A_in(A_in), .B_in(B_in), .A_out(A_out), .B_out(B_out),
      .ZNC_out(ZNC_out), .BR_out(BR_out), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Architectural effect of one retired op, straight from the class rules.
   task automatic model_op(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
      int unsigned x, y, r;
      int          c;
      int          ad;
      c  = int'(op[15:12]);
      ad = int'(op[7:0]);
      case (c)
         1, 2, 6: begin
            x = (c == 2) ? int'(b) : int'(a);
            y = (c == 6) ? int'(b) : 1;
            r = x + y;
            if (c == 2) begin m_a = a; m_b = 16'(r % 65536); end
            else begin m_a = 16'(r % 65536); m_b = b; end
            m_znc = {(r % 65536) == 0, (r % 65536) >= 32768, r >= 65536};
            m_br  = 1'b0;
         end
         3: begin m_a = m_ram[ad]; m_b = b; m_br = 1'b0; end
         4: begin m_ram[ad] = b; m_a = a; m_b = b; m_br = 1'b0; end
         5: begin m_a = a; m_b = b; m_br = (op[2:0] & m_znc) != 3'b000; end
         default: m_br = 1'b0;
      endcase
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_A"}, A_out, m_a);
      check({tag, "_B"}, B_out, m_b);
      check({tag, "_ZNC"}, ZNC_out, m_znc);
      check({tag, "_BR"}, BR_out, m_br);
   endtask

   // Called at posedge+1 with the unit idle; returns at posedge+1 back in IDLE.
   task automatic run_op(input string tag, input logic [15:0] op, input logic [15:0] a,
                         input logic [15:0] b);
      int lat;
      opCode = op; A_in = a; B_in = b; op_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, op_ready, 1'b1);
      check({tag, "_done_idle"}, done, 1'b0);
      @(posedge clk);
      #1 op_valid = 1'b0;
      opCode = 16'($urandom);
      model_op(op, a, b);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      check({tag, "_lat"}, lat, (op[15:12] == 4'd3) ? 3 : 2);
      check_outs(tag);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 4))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] pa, pb, op;
      logic [2:0]  pz;
      logic [3:0]  c4;
      logic [11:0] acc_mask, done_mask;

      rst_n = 1'b0; en = 1'b0; op_valid = 1'b0; opCode = '0; A_in = '0; B_in = '0;
      m_a = '0; m_b = '0; m_znc = '0; m_br = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset");
      check("reset_done", done, 1'b0);
      rst_n = 1'b1; en = 1'b1;
      @(negedge clk);
      check("reset_ready", op_ready, 1'b1);
      @(posedge clk);
      #1;

      // Wrap-around add, then ST/LD round trip keeping the ALU flags.
      run_op("add_wrap", {4'd6, 12'h000}, 16'hFFFF, 16'h0001);
      check("add_wrap_A0", A_out, 16'h0000);
      check("add_wrap_znc", ZNC_out, 3'b101);
      run_op("st10", {4'd4, 4'h0, 8'h10}, 16'h1111, 16'h8000);
      run_op("ld10", {4'd3, 4'h0, 8'h10}, 16'h2222, 16'h3333);
      check("ld10_data", A_out, 16'h8000);
      check("ld10_znc", ZNC_out, 3'b101);

      // Branch on N after INCA overflows into the sign bit; a NOP clears it.
      run_op("inca", {4'd1, 12'h000}, 16'h7FFF, 16'h0042);
      run_op("br_n", {4'd5, 9'h0, 3'b010}, 16'h0005, 16'h0006);
      check("br_taken", BR_out, 1'b1);
      run_op("nop", {4'd0, 12'h000}, 16'h0009, 16'h000A);
      check("br_clear", BR_out, 1'b0);
      run_op("incb", {4'd2, 12'h000}, 16'h0003, 16'hFFFF);

      // en low for 4 cycles while in EXEC.
      pa = m_a; pb = m_b; pz = m_znc;
      opCode = {4'd1, 12'h000}; A_in = 16'h0010; B_in = 16'h0020; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0; en = 1'b0;
      model_op({4'd1, 12'h000}, 16'h0010, 16'h0020);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stall_done", done, 1'b0);
         check("stall_ready", op_ready, 1'b0);
         check("stall_A", A_out, pa);
         check("stall_B", B_out, pb);
         check("stall_ZNC", ZNC_out, pz);
      end
      @(posedge clk);
      #1 en = 1'b1;
      @(negedge clk);
      check("stall_resume_exec", done, 1'b0);
      @(negedge clk);
      check("stall_retire", done, 1'b1);
      check_outs("stall");
      @(posedge clk);
      #1;

      // op_valid held high with class 9: accepts only from IDLE, every 3 cycles.
      opCode = {4'd9, 12'hABC}; A_in = 16'h1357; B_in = 16'h2468; op_valid = 1'b1;
      acc_mask = '0; done_mask = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         acc_mask[k]  = op_ready;
         done_mask[k] = done;
      end
      @(posedge clk);
      #1 op_valid = 1'b0;
      for (int k = 0; k < 4; k++) model_op({4'd9, 12'hABC}, 16'h1357, 16'h2468);
      check("held_accepts", acc_mask, 12'b001001001001);
      check("held_dones", done_mask, 12'b100100100100);
      check_outs("held");

      // Randomized sequence over a small, fully initialised address window.
      for (int i = 0; i < 8; i++) run_op("init_st", {4'd4, 4'h0, 8'(i)}, pick(), pick());
      for (int i = 0; i < 200; i++) begin
         c4 = 4'($urandom_range(0, 15));
         op = {c4, 4'($urandom), 5'b0, 3'($urandom)};
         run_op("rand", op, pick(), pick());
      end

      // Reset in the MEM cycle of a LD aborts it.
      run_op("pre_rst_st", {4'd4, 4'h0, 8'h01}, 16'h1234, 16'h5678);
      opCode = {4'd3, 4'h0, 8'h01}; A_in = 16'h4321; B_in = 16'h8765; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      m_a = '0; m_b = '0; m_znc = '0; m_br = 1'b0;
      check_outs("mid_rst");
      check("mid_rst_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_done", done, 1'b0);
         check("post_rst_ready", op_ready, 1'b1);
      end
      check_outs("post_rst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/green_exec.md
GREEN_EXEC -- requirements
Module: green_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand/result/RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning RAM address width; RAM depth is 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  global enable; when 0, FSM, registers and RAM writes hold.
REQ-006 SHALL have port op_valid  input  1  opCode/A_in/B_in presented for issue.
REQ-007 SHALL have port op_ready  output  1  unit can accept an op this cycle.
REQ-008 SHALL have port opCode  input  16  operation; [15:12] class, [ADDR_W-1:0] RAM address, [2:0] branch mask.
REQ-009 SHALL have ports A_in, B_in  input  DATA_W  operands.
REQ-010 SHALL have ports A_out, B_out  output  DATA_W  registered results.
REQ-011 SHALL have port ZNC_out  output  3  registered flags {Z,N,C}.
REQ-012 SHALL have port BR_out  output  1  registered branch-taken.
REQ-013 SHALL have port done  output  1  one-cycle pulse when an op retires.

Function
REQ-014 SHALL use FSM states IDLE, EXEC, MEM, WB; op_ready = (state==IDLE) & en.
REQ-015 SHALL accept an op when op_valid & op_ready; it latches opCode, A_in and B_in, then moves IDLE->EXEC.
REQ-016 SHALL decode class: 0 NOP, 1 INCA (A+1), 2 INCB (B+1), 3 LD, 4 ST, 5 BR, 6 ADD (A+B); classes 7-15 SHALL act as NOP.
REQ-017 SHALL transition EXEC->MEM for LD and EXEC->WB for all other classes; MEM->WB; WB->IDLE, all only while en=1.
REQ-018 SHALL register results on the edge entering WB and assert done for exactly the WB cycle.
REQ-019 SHALL give latency from acceptance edge to done of 2 cycles (non-LD) and 3 cycles (LD), with en held 1.
REQ-020 SHALL for INCA/ADD write A_out=result[DATA_W-1:0], B_out=latched B; for INCB write B_out=B+1, A_out=latched A.
REQ-021 SHALL compute C as the carry out of bit DATA_W-1 of the INC/ADD sum; Z=(A_out==0), N=A_out[DATA_W-1]; INCB SHALL use B_out for Z/N.
REQ-022 SHALL wrap arithmetic modulo 2**DATA_W (e.g. all-ones + 1 = 0 with C=1).
REQ-023 SHALL for LD read RAM[addr] synchronously in MEM and write A_out=data, B_out=latched B; ZNC_out unchanged.
REQ-024 SHALL for ST write RAM[addr]=latched B on the EXEC->WB edge; A_out/B_out pass latched A/B; ZNC_out unchanged.
REQ-025 SHALL for BR set BR_out = |(opCode[2:0] & ZNC_out) using flags before this op; A/B pass through; ZNC_out unchanged.
REQ-026 SHALL clear BR_out at WB of any non-BR op; BR_out otherwise holds.
REQ-027 SHALL for NOP/unknown classes retire with done and leave A_out, B_out, ZNC_out unchanged.
REQ-028 SHALL ignore op_valid while not in IDLE; an op presented then is neither accepted nor lost-signalled (op_ready=0).
REQ-029 SHALL, with en=0 in any state, freeze state, outputs and RAM; done SHALL be 0 while en=0.
REQ-030 SHALL give LD immediately after ST to the same address the newly stored value.
REQ-031 SHALL take addresses as opCode[ADDR_W-1:0] with no out-of-range case.

Reset
REQ-032 SHALL on rst_n=0 asynchronously force state=IDLE, A_out=0, B_out=0, ZNC_out=3'b000, BR_out=0, done=0.
REQ-033 SHALL abort any in-flight op on reset without retiring it; an in-progress ST not yet at its write edge SHALL NOT write.
REQ-034 SHALL NOT reset RAM contents; contents after reset are unspecified.
REQ-035 SHALL present op_ready=1 in the first en=1 cycle after rst_n deasserts.

Verification
REQ-036 ADD A=16'hFFFF, B=16'h0001 -> done 2 cycles after accept; A_out=0, ZNC_out=3'b101.
REQ-037 ST addr 8'h10 B=16'h8000, then LD addr 8'h10 -> LD done 3 cycles after accept; A_out=16'h8000; ZNC_out unchanged from the previous ALU op.
REQ-038 INCA A=16'h7FFF, then BR mask 3'b010 -> BR_out=1; the following NOP -> BR_out=0.
REQ-039 en=0 for 4 cycles while in EXEC -> state, outputs and done frozen; retires 1 cycle after en returns to 1.
REQ-040 rst_n low in MEM of LD -> all outputs 0 immediately; no done; op_ready=1 after release.
REQ-041 op_valid held high throughout -> ops accepted only in IDLE, one per 3 cycles (non-LD); class 9 retires as NOP.
